// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: PC, direct-mapped icache, BHT/JAL next-PC prediction
// Presents one instruction per cycle to the decoder; fills misses through the memory controller.
module ifetch_unit #(
   parameter int          ICACHE_IDX_W = 4,
   parameter int          BHT_IDX_W    = 8,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        issue_stall,
   output logic        inst_rdy,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_pred_jump,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   input  logic        rollback,
   input  logic [31:0] rollback_pc,
   input  logic        br_commit,
   input  logic [31:0] br_pc,
   input  logic        br_taken
);

   localparam int TAG_W = 30 - ICACHE_IDX_W;
   localparam int LINES = 1 << ICACHE_IDX_W;
   localparam int BHT_N = 1 << BHT_IDX_W;

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_WAIT_MEM = 1'b1;

   logic [0:0]        state;
   logic [31:0]       pc;
   logic [31:2]       req_addr;
   logic [LINES-1:0]  line_valid;
   logic [TAG_W-1:0]  line_tag  [LINES];
   logic [31:0]       line_data [LINES];
   logic [1:0]        bht       [BHT_N];

   logic [ICACHE_IDX_W-1:0] pc_idx, req_idx;
   logic [TAG_W-1:0]        pc_tag, req_tag;
   logic [BHT_IDX_W-1:0]    pc_bht_idx, br_bht_idx;
   logic                    hit;
   logic [31:0]             hit_word;
   logic [31:0]             npc;
   logic                    pred;
   logic [31:0]             jal_off, br_off;
   logic                    fill;
   logic                    unused_ok;

   assign pc_idx     = pc[ICACHE_IDX_W+1:2];
   assign pc_tag     = pc[31:ICACHE_IDX_W+2];
   assign req_idx    = req_addr[ICACHE_IDX_W+1:2];
   assign req_tag    = req_addr[31:ICACHE_IDX_W+2];
   assign pc_bht_idx = pc[BHT_IDX_W+1:2];
   assign br_bht_idx = br_pc[BHT_IDX_W+1:2];
   assign unused_ok  = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};

   assign hit      = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
   assign hit_word = line_data[pc_idx];
   assign fill     = (state == S_WAIT_MEM) && mem_done;

   assign jal_off = {{12{hit_word[31]}}, hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
   assign br_off  = {{20{hit_word[31]}}, hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};

   always_comb begin
      npc  = pc + 32'd4;
      pred = 1'b0;
      case (hit_word[6:0])
         7'b1101111: begin
            npc  = pc + jal_off;
            pred = 1'b1;
         end
         7'b1100011: begin
            if (bht[pc_bht_idx][1]) begin
               npc  = pc + br_off;
               pred = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         pc             <= RESET_PC;
         req_addr       <= '0;
         inst_rdy       <= 1'b0;
         inst           <= '0;
         inst_pc        <= '0;
         inst_pred_jump <= 1'b0;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         line_valid     <= '0;
         for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
      end else if (rdy) begin
         // Rollback wins over a same-cycle fetch; an outstanding fill still completes.
         if (rollback) begin
            pc       <= rollback_pc;
            inst_rdy <= 1'b0;
         end else if (hit && !issue_stall) begin
            inst_rdy       <= 1'b1;
            inst           <= hit_word;
            inst_pc        <= pc;
            inst_pred_jump <= pred;
            pc             <= npc;
         end else begin
            inst_rdy <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (!hit && !rollback) begin
                  mem_req  <= 1'b1;
                  mem_addr <= {pc[31:2], 2'b00};
                  req_addr <= pc[31:2];
                  state    <= S_WAIT_MEM;
               end
            end
            S_WAIT_MEM: begin
               if (mem_done) begin
                  line_valid[req_idx] <= 1'b1;
                  mem_req             <= 1'b0;
                  state               <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (br_commit) begin
            if (br_taken && bht[br_bht_idx] != 2'b11)
               bht[br_bht_idx] <= bht[br_bht_idx] + 2'b01;
            else if (!br_taken && bht[br_bht_idx] != 2'b00)
               bht[br_bht_idx] <= bht[br_bht_idx] - 2'b01;
         end
      end
   end

   // Line payload needs no reset: the valid bits gate every lookup.
   always_ff @(posedge clk) begin
      if (rdy && fill) begin
         line_tag[req_idx]  <= req_tag;
         line_data[req_idx] <= mem_data;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
// Directed phases push expected instructions and memory requests; a negedge monitor pops and compares.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        issue_stall = 1'b0;
   logic        inst_rdy;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_pred_jump;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done = 1'b0;
   logic [31:0] mem_data = '0;
   logic        rollback = 1'b0;
   logic [31:0] rollback_pc = '0;
   logic        br_commit = 1'b0;
   logic [31:0] br_pc = '0;
   logic        br_taken = 1'b0;

   localparam logic [31:0] W_ADDI = 32'h00000013;
   localparam logic [31:0] W_JAL  = 32'h0100006F;
   localparam logic [31:0] W_BEQ  = 32'hFE000CE3;
   localparam logic [31:0] W_SELF = 32'h0000006F;
   localparam logic [31:0] W_40   = 32'h00100093;
   localparam logic [31:0] W_100  = 32'h00200113;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic        pred;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] req_q[$];
   exp_t        mon_e;
   logic [31:0] mon_a;
   logic        req_prev = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   ifetch_unit #(.ICACHE_IDX_W(4), .BHT_IDX_W(8), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .issue_stall(issue_stall),
      .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc), .inst_pred_jump(inst_pred_jump),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
      .rollback(rollback), .rollback_pc(rollback_pc),
      .br_commit(br_commit), .br_pc(br_pc), .br_taken(br_taken)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h08:  return W_JAL;
         32'h20:  return W_BEQ;
         32'h24:  return W_SELF;
         32'h40:  return W_40;
         32'h100: return W_100;
         default: return W_ADDI;
      endcase
   endfunction

   // Memory controller model: fixed 3-cycle latency, drops a request that vanished (reset).
   initial begin
      forever begin
         @(negedge clk);
         if (mem_req && rst) begin
            repeat (3) @(negedge clk);
            if (mem_req && rst) begin
               mem_data = mem_word(mem_addr);
               mem_done = 1'b1;
               @(negedge clk);
               mem_done = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst && inst_rdy) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_inst: got pc=%h inst=%h pred=%b, required no instruction",
                     inst_pc, inst, inst_pred_jump);
         end else begin
            mon_e = exp_q.pop_front();
            if (inst_pc !== mon_e.pc || inst !== mon_e.word || inst_pred_jump !== mon_e.pred) begin
               n_fail++;
               $display("FAIL inst_stream: got pc=%h inst=%h pred=%b, required pc=%h inst=%h pred=%b",
                        inst_pc, inst, inst_pred_jump, mon_e.pc, mon_e.word, mon_e.pred);
            end
         end
      end
      if (mem_req && !req_prev) begin
         n_tests++;
         if (req_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_req: got mem_addr=%h, required no request", mem_addr);
         end else begin
            mon_a = req_q.pop_front();
            if (mem_addr !== mon_a) begin
               n_fail++;
               $display("FAIL mem_req_addr: got %h, required %h", mem_addr, mon_a);
            end
         end
      end
      req_prev = mem_req;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] p, input logic [31:0] w, input logic pr);
      exp_t e;
      e.pc = p;
      e.word = w;
      e.pred = pr;
      exp_q.push_back(e);
   endtask

   task automatic wait_inst_pc(input logic [31:0] p);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (inst_rdy && inst_pc == p) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL timeout_inst: got no instruction, required pc=%h", p);
   endtask

   task automatic wait_req(input logic [31:0] a);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mem_req && mem_addr == a) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL timeout_req: got no request, required mem_addr=%h", a);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_inst_rdy"}, {31'b0, inst_rdy}, 32'h0);
      check({tag, "_inst"}, inst, 32'h0);
      check({tag, "_inst_pc"}, inst_pc, 32'h0);
      check({tag, "_pred"}, {31'b0, inst_pred_jump}, 32'h0);
      check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
   endtask

   initial begin
      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");

      // Cold start: every line misses once; JAL at 0x8 jumps to 0x18.
      foreach (mem_addr[i]) ;
      req_q.push_back(32'h00); req_q.push_back(32'h04); req_q.push_back(32'h08);
      req_q.push_back(32'h18); req_q.push_back(32'h1C); req_q.push_back(32'h20);
      req_q.push_back(32'h24);
      push_exp(32'h00, W_ADDI, 1'b0);
      push_exp(32'h04, W_ADDI, 1'b0);
      push_exp(32'h08, W_JAL,  1'b1);
      push_exp(32'h18, W_ADDI, 1'b0);
      push_exp(32'h1C, W_ADDI, 1'b0);
      push_exp(32'h20, W_BEQ,  1'b0);
      rst = 1'b1;
      wait_inst_pc(32'h20);
      issue_stall = 1'b1;
      repeat (12) @(negedge clk);

      // Three taken commits: 1 -> 2 -> 3 -> 3 (saturate high).
      br_commit = 1'b1; br_pc = 32'h20; br_taken = 1'b1;
      repeat (3) @(negedge clk);
      br_commit = 1'b0;
      rollback = 1'b1; rollback_pc = 32'h20;
      @(negedge clk);
      rollback = 1'b0;
      push_exp(32'h20, W_BEQ, 1'b1);
      issue_stall = 1'b0;
      wait_inst_pc(32'h20);
      issue_stall = 1'b1;
      push_exp(32'h18, W_ADDI, 1'b0);
      issue_stall = 1'b0;
      wait_inst_pc(32'h18);
      issue_stall = 1'b1;

      // Four not-taken commits: 3 -> 2 -> 1 -> 0 -> 0 (saturate low).
      br_commit = 1'b1; br_taken = 1'b0;
      repeat (4) @(negedge clk);
      br_commit = 1'b0;
      rollback = 1'b1; rollback_pc = 32'h20;
      @(negedge clk);
      rollback = 1'b0;
      push_exp(32'h20, W_BEQ,  1'b0);
      push_exp(32'h24, W_SELF, 1'b1);
      issue_stall = 1'b0;
      wait_inst_pc(32'h24);
      issue_stall = 1'b1;

      // Stall with a hit pending, then a global-enable hold, then exactly one delivery.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_no_inst", {31'b0, inst_rdy}, 32'h0);
      end
      rdy = 1'b0;
      issue_stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rdy0_no_inst", {31'b0, inst_rdy}, 32'h0);
      end
      push_exp(32'h24, W_SELF, 1'b1);
      rdy = 1'b1;
      wait_inst_pc(32'h24);
      issue_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("once_no_inst", {31'b0, inst_rdy}, 32'h0);
      end

      // Rollback during an outstanding fill: request held, then refetch from 0x100.
      issue_stall = 1'b0;
      req_q.push_back(32'h40);
      rollback = 1'b1; rollback_pc = 32'h40;
      @(negedge clk);
      rollback = 1'b0;
      wait_req(32'h40);
      req_q.push_back(32'h100);
      req_q.push_back(32'h104);
      push_exp(32'h100, W_100, 1'b0);
      rollback = 1'b1; rollback_pc = 32'h100;
      @(negedge clk);
      rollback = 1'b0;
      check("held_req_1", {31'b0, mem_req}, 32'h1);
      @(negedge clk);
      check("held_req_2", {31'b0, mem_req}, 32'h1);
      check("held_addr", mem_addr, 32'h40);
      wait_inst_pc(32'h100);
      issue_stall = 1'b1;
      repeat (12) @(negedge clk);

      // Asynchronous reset while waiting on memory.
      req_q.push_back(32'h200);
      rollback = 1'b1; rollback_pc = 32'h200;
      @(negedge clk);
      rollback = 1'b0;
      wait_req(32'h200);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check_outputs_zero("midreset");
      repeat (5) @(negedge clk);
      req_q.push_back(32'h00);
      rst = 1'b1;
      repeat (12) @(negedge clk);

      check("exp_q_drained", exp_q.size(), 32'h0);
      check("req_q_drained", req_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the combinational decoder. It holds the architectural fetch PC and a direct-mapped instruction cache, and fills misses through the memory controller. It predicts next-PC with a 2-bit branch history table and JAL target computation. It presents one instruction per cycle to the decoder as inst_rdy/inst/inst_pc/inst_pred_jump, and redirects on ROB rollback.

Parameters:
ICACHE_IDX_W, 4, log2 of icache lines; one 32-bit word per line, tag = pc[31:ICACHE_IDX_W+2]
BHT_IDX_W, 8, log2 of BHT entries; index = pc[BHT_IDX_W+1:2]
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global enable; when 0 all state holds
issue_stall  in  1  downstream (ROB/RS/LSB) cannot accept an instruction next cycle
inst_rdy  out  1  registered; instruction valid to decoder this cycle
inst  out  32  instruction word
inst_pc  out  32  PC of inst
inst_pred_jump  out  1  1 = predicted taken (JAL, or BR predicted taken)
mem_req  out  1  registered; fetch request to memory controller
mem_addr  out  32  word address of request (low 2 bits 0)
mem_done  in  1  one-cycle pulse; mem_data valid
mem_data  in  32  fetched word
rollback  in  1  ROB misprediction flush
rollback_pc  in  32  correct PC after flush
br_commit  in  1  ROB commits a conditional branch
br_pc  in  32  PC of committed branch
br_taken  in  1  actual outcome

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, inst_rdy=0, inst=0, inst_pc=0, inst_pred_jump=0, mem_req=0, mem_addr=0. All icache valid bits = 0. All BHT counters = 2'b01 (weakly not-taken).
- rdy=0: no register changes, including BHT and cache fill. mem_done arriving while rdy=0 is the controller's responsibility to hold.
- Hit = valid[idx(pc)] && tag matches. Lookup is combinational on the current pc.
- Fetch rule, each cycle with rdy=1 and rollback=0:
  - If hit and !issue_stall: next cycle inst_rdy=1, inst=line, inst_pc=pc, inst_pred_jump=pred, pc<=npc.
  - Otherwise: next cycle inst_rdy=0.
- Prediction from the hit word (opcode = inst[6:0]):
  - JAL (1101111): npc = pc + {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}, pred=1.
  - BR (1100011): if bht[pc][1] then npc = pc + {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}, pred=1; else npc=pc+4, pred=0.
  - All others, including JALR: npc=pc+4, pred=0.
  - Adds are 32-bit modulo.
- Latency: on a hit, inst_rdy is asserted the cycle after the pc was presented, giving 1 instruction/cycle throughput. issue_stall must already include one slot of margin, because the decoder issues in the cycle inst_rdy is high.
- Miss FSM (IDLE, WAIT_MEM):
  - IDLE, miss, rollback=0: mem_req<=1, mem_addr<=pc, req_addr<=pc, go to WAIT_MEM.
  - WAIT_MEM: mem_req stays 1 until mem_done. On mem_done: write line[idx(req_addr)]={tag,mem_data}, set valid, mem_req<=0, go to IDLE. The fill hits on the next cycle if pc still equals req_addr.
  - Only one outstanding request is allowed.
- Rollback (rdy=1):
  - pc<=rollback_pc; inst_rdy<=0 next cycle. It overrides any fetch in the same cycle.
  - In WAIT_MEM the request is not cancelled. The fill completes into the cache (it is valid for req_addr), then the FSM returns to IDLE and resumes from the new pc.
  - Rollback and mem_done in the same cycle: both take effect.
- BHT update on br_commit (rdy=1), at index of br_pc: saturating counter, +1 if br_taken (max 3), -1 otherwise (min 0). When a same-cycle read hits the same index, the read sees the old value.
- Self-modifying code is not supported; the icache is never invalidated except by reset.

Test Plan:
- Reset, memory holds 0x00000013 (addi) at 0x0 and 0x4 -> miss, mem_req=1 with mem_addr=0x0. After mem_done: inst_rdy=1, inst=0x00000013, inst_pc=0x0, inst_pred_jump=0. Next fetch requests 0x4.
- JAL x0,+16 (0x0100006F) cached at 0x8 -> inst_rdy with inst_pc=0x8, inst_pred_jump=1. Next inst_pc=0x18.
- BEQ offset -8 at 0x20, BHT at reset value -> pred=0, next pc 0x24. Two br_commit taken at 0x20 (counter reaches 3), re-fetch 0x20 -> pred=1, next pc 0x18. Four not-taken commits -> counter saturates at 0.
- issue_stall=1 for 3 cycles with hit available -> inst_rdy=0, pc unchanged. Stall released -> same instruction delivered exactly once.
- Rollback to 0x100 while WAIT_MEM for 0x40 -> mem_req held until mem_done, line for 0x40 filled, then request 0x100. No instruction from 0x40 is emitted.
- rst pulsed low mid-WAIT_MEM -> all outputs 0, pc=RESET_PC, cache invalid. Next request is to 0x0.
